// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder for the MEM stage
//
// Accepts one load/store request at a time, services it LATENCY cycles after
// accept and pulses Done in the completion cycle. Stall freezes the pipeline
// while a request is outstanding.
//
// Parameters:
//   DEPTH    words of storage (power of two, 4..4096)
//   LATENCY  cycles from accept to Done (1..15)
//
// Ports:
//   clk         clock, rising-edge
//   reset       synchronous, active-high
//   MemEn       request valid, held by the pipeline until Done
//   MemWrite    1 = store, 0 = load (sampled at accept)
//   Addr        byte address; word index = Addr[$clog2(DEPTH)+1:2]
//   WriteData   store data (sampled at accept)
//   ReadData    load data, valid in the Done cycle and held afterwards
//   Done        one-cycle completion pulse
//   Stall       MemEn & ~Done
//   AlignFault  only when DMEM_ALIGN_CHECK_EN is defined: misaligned access,
//               high in the Done cycle only
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemEn,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Stall
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        AlignFault
`endif
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      cnt;
    logic            commit;
    logic            accept;

    logic            lat_write;
    logic [IW-1:0]   lat_idx;
    logic [31:0]     lat_data;

    // Request as seen at the commit edge. With LATENCY==1 the commit edge is
    // the accept edge, so the live inputs are used; otherwise the latched copy.
    logic            cur_write;
    logic [IW-1:0]   cur_idx;
    logic [31:0]     cur_data;
    logic            cur_mis;

    logic [31:0]     mem [DEPTH];

    logic            unused_addr_bits;
    assign unused_addr_bits = &{1'b0, Addr[31:IW+2], Addr[1:0]};

    assign accept    = (state == IDLE) && MemEn;
    assign cur_write = (state == IDLE) ? MemWrite        : lat_write;
    assign cur_idx   = (state == IDLE) ? Addr[IW+1:2]    : lat_idx;
    assign cur_data  = (state == IDLE) ? WriteData       : lat_data;

`ifdef DMEM_ALIGN_CHECK_EN
    logic lat_mis;
    assign cur_mis    = (state == IDLE) ? (Addr[1:0] != 2'b00) : lat_mis;
    assign AlignFault = Done & lat_mis;
`else
    assign cur_mis    = 1'b0;
`endif

    assign Done  = (state == DONE);
    assign Stall = MemEn & ~Done;

    always_comb begin
        next_state = state;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (MemEn) begin
                    next_state = (LATENCY > 1) ? WAIT : DONE;
                    commit     = (LATENCY == 1);
                end
            end
            WAIT: begin
                // cnt==1 marks the last WAIT cycle, i.e. cycle T+LATENCY-1
                if (cnt == 4'd1) begin
                    next_state = DONE;
                    commit     = 1'b1;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_data  <= 32'd0;
            ReadData  <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
            lat_mis   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                lat_write <= MemWrite;
                lat_idx   <= Addr[IW+1:2];
                lat_data  <= WriteData;
                cnt       <= 4'(LATENCY - 1);
`ifdef DMEM_ALIGN_CHECK_EN
                lat_mis   <= (Addr[1:0] != 2'b00);
`endif
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // Loads read the pre-store contents; misaligned accesses return 0.
            if (commit && (cur_mis || !cur_write)) begin
                ReadData <= cur_mis ? 32'd0 : mem[cur_idx];
            end
        end
    end

    // Storage is deliberately not reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_write && !cur_mis) begin
            mem[cur_idx] <= cur_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized scoreboard bench for dmem_responder

module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemEn;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Done;
    logic        Stall;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        AlignFault;
`endif

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .MemEn(MemEn),
        .MemWrite(MemWrite),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Done(Done),
        .Stall(Stall)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .AlignFault(AlignFault)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        logic [31:0] rd;
        bit          fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem[DEPTH];
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && Done) begin
            if (sb.size() == 0) begin
                check32("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check32("done_cycle", cyc, e.done_cyc);
                check32("read_data", ReadData, e.rd);
`ifdef DMEM_ALIGN_CHECK_EN
                check32("align_fault", {31'd0, AlignFault}, {31'd0, e.fault});
`endif
            end
        end
`ifdef DMEM_ALIGN_CHECK_EN
        if (!reset && !Done && AlignFault) check32("align_fault_idle", 32'd1, 32'd0);
`endif
    end

    // mode 0: inputs held; 1: Addr/WriteData changed to pa/pd while waiting;
    // 2: all inputs including MemEn randomized while waiting.
    task automatic req(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input int mode, input logic [31:0] pa, input logic [31:0] pd);
        exp_t e;
        int   idx;
        bit   mis;
        bit   seen;
        @(posedge clk); #1;
        MemEn     = 1'b1;
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        idx = int'((a >> 2) % DEPTH);
        mis = ALIGN && (a[1:0] != 2'b00);
        e.done_cyc = cyc + LAT;
        e.fault    = mis;
        if (mis) begin
            e.rd    = 32'd0;
            last_rd = 32'd0;
        end else if (we) begin
            model_mem[idx] = d;
            e.rd = last_rd;
        end else begin
            e.rd    = model_mem[idx];
            last_rd = e.rd;
        end
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k <= LAT + 4 && !seen; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (mode == 1) begin
                    Addr      = pa;
                    WriteData = pd;
                end else if (mode == 2) begin
                    Addr      = $urandom;
                    WriteData = $urandom;
                    MemWrite  = 1'($urandom);
                    MemEn     = 1'($urandom);
                end
            end
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
                check32("stall_in_done", {31'd0, Stall}, 32'd0);
            end else begin
                check32("stall_pending", {31'd0, Stall}, {31'd0, MemEn});
            end
        end
        if (!seen) check32("done_timeout", 32'd0, 32'd1);
        MemEn = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        MemEn     = 1'b0;
        MemWrite  = 1'b0;
        Addr      = 32'd0;
        WriteData = 32'd0;
        last_rd   = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("reset_stall", {31'd0, Stall}, 32'd0);
        check32("reset_done", {31'd0, Done}, 32'd0);
        check32("reset_read_data", ReadData, 32'd0);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) req(1'b1, 32'(i * 4), $urandom, 0, 32'd0, 32'd0);

        req(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'd0, 32'd0);
        req(1'b0, 32'h10, 32'd0, 0, 32'd0, 32'd0);

        // Address wrap: 0x100 aliases word 0.
        req(1'b1, 32'h100, 32'h12345678, 0, 32'd0, 32'd0);
        req(1'b0, 32'h000, 32'd0, 0, 32'd0, 32'd0);

        // Inputs changed while waiting must be ignored.
        req(1'b1, 32'h20, 32'hAAAA0000, 1, 32'h24, 32'h5555);
        req(1'b0, 32'h20, 32'd0, 0, 32'd0, 32'd0);
        req(1'b0, 32'h24, 32'd0, 0, 32'd0, 32'd0);

        // Reset during the first WAIT cycle discards the pending store.
        req(1'b1, 32'h30, 32'h0, 0, 32'd0, 32'd0);
        @(posedge clk); #1;
        MemEn = 1'b1; MemWrite = 1'b1; Addr = 32'h30; WriteData = 32'h1;
        @(posedge clk); #1;
        reset = 1'b1; MemEn = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        check32("midreset_done", {31'd0, Done}, 32'd0);
        check32("midreset_stall", {31'd0, Stall}, 32'd0);
        check32("midreset_read_data", ReadData, 32'd0);
        repeat (3) @(negedge clk);
        req(1'b0, 32'h30, 32'd0, 0, 32'd0, 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
        req(1'b1, 32'h13, 32'hCAFEF00D, 0, 32'd0, 32'd0);
        req(1'b0, 32'h10, 32'd0, 0, 32'd0, 32'd0);
`endif

        for (int n = 0; n < 200; n++) begin
            req(1'($urandom), $urandom & 32'h0000_FFFF, $urandom,
                $urandom_range(0, 2), $urandom, $urandom);
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end

        repeat (LAT + 4) @(negedge clk);
        check32("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
